spwm_rate_sched: RTL and testbench
==================================

SPWM_RATE_SCHED -- requirements
Module: spwm_rate_sched

Interface
REQ-001 Parameter DIV_W, default 13, width of all divider values.
REQ-002 Parameter DIV_DEFAULT, default 196, half-period terminal count after reset.
REQ-003 Parameter DIV_MIN, default 49, lowest legal terminal count.
REQ-004 Parameter STEP_HALF, default 64, carrier half-periods between ramp steps (>=1).
REQ-005 clk_in  input  1  system clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  run request; low stops carrier.
REQ-008 cmd_valid  input  1  new target divider offered.
REQ-009 cmd_div  input  DIV_W  requested half-period terminal count.
REQ-010 cmd_ready  output  1  command acceptable this cycle.
REQ-011 car_clk  output  1  registered carrier square wave.
REQ-012 tick  output  1  one-cycle pulse at each half-period wrap.
REQ-013 cur_div  output  DIV_W  terminal count in use.
REQ-014 ramping  output  1  high while in RAMP.
REQ-015 cmd_clamped  output  1  one-cycle pulse: accepted command raised to DIV_MIN.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and RAMP; all logic is synchronous to clk_in except reset.
REQ-017 In RUN/RAMP a counter SHALL count 0..cur_div; at cur_div it returns to 0, car_clk toggles, tick=1 that cycle (half-period = cur_div+1 cycles).
REQ-018 In IDLE counter SHALL be held 0, car_clk 0, tick 0.
REQ-019 cmd_ready SHALL be 1 in IDLE and RUN, 0 in RAMP (combinational from state).
REQ-020 A command SHALL be accepted only when cmd_valid && cmd_ready; target = max(cmd_div, DIV_MIN); cmd_clamped pulses the next cycle if cmd_div < DIV_MIN.
REQ-021 A command accepted in IDLE SHALL load target and cur_div together on the next edge (no ramp while stopped).
REQ-022 IDLE -> RUN when enable=1 and target==cur_div; IDLE -> RAMP when enable=1 and target!=cur_div; a command accepted in the same cycle is applied first.
REQ-023 A command accepted in RUN with target!=cur_div SHALL move the FSM to RAMP next cycle; equal target leaves RUN unchanged.
REQ-024 In RAMP a dwell counter SHALL increment on each tick; on the tick where dwell==STEP_HALF-1, cur_div steps by 1 toward target, effective at that wrap, and dwell clears.
REQ-025 cur_div SHALL change only on a tick cycle in RUN/RAMP, so no half-period is ever truncated.
REQ-026 When the stepped cur_div equals target the FSM SHALL enter RUN next cycle; ramping falls then.
REQ-027 enable=0 in any state SHALL force IDLE on the next edge; cur_div, target retained; dwell cleared.
REQ-028 Arithmetic SHALL be unsigned DIV_W-bit; the counter never exceeds cur_div and never wraps through 2^DIV_W.

Reset
REQ-029 On reset assertion, immediately: state IDLE, counter 0, dwell 0, car_clk 0, tick 0, cmd_clamped 0, cur_div=target=DIV_DEFAULT; cmd_ready=1.
REQ-030 Reset asserted mid-RAMP SHALL abort the ramp with no further cur_div step.

Verification
REQ-031 Reset release, enable=1, no command -> tick every 197 cycles, car_clk period 394 cycles, cur_div=196.
REQ-032 IDLE, cmd_div=99 accepted, then enable=1 -> cur_div=99 one cycle after acceptance, ticks every 100 cycles, ramping stays 0.
REQ-033 STEP_HALF=2, RUN at 196, cmd_div=194 -> cmd_ready 0, cur_div=195 at 2nd tick, 194 at 4th tick, RUN and cmd_ready=1 next cycle.
REQ-034 cmd_div=10 accepted -> target 49, cmd_clamped pulses exactly one cycle.
REQ-035 enable dropped mid-RAMP at cur_div=195, target 194 -> next cycle IDLE, car_clk 0, counter 0; re-enable -> RAMP, resumes stepping to 194.
REQ-036 Async reset asserted mid-half-period during RAMP -> all REQ-029 values without waiting for a clk_in edge.

Source files
------------

// File: rtl/spwm_rate_sched.sv
// Carrier rate scheduler: generates a square-wave carrier whose half-period
// divider ramps one count at a time toward a commanded target.
module spwm_rate_sched #(
   parameter int DIV_W       = 13,
   parameter int DIV_DEFAULT = 196,
   parameter int DIV_MIN     = 49,
   parameter int STEP_HALF   = 64
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             cmd_valid,
   input  logic [DIV_W-1:0] cmd_div,
   output logic             cmd_ready,
   output logic             car_clk,
   output logic             tick,
   output logic [DIV_W-1:0] cur_div,
   output logic             ramping,
   output logic             cmd_clamped
);

   localparam int                DWELL_W    = (STEP_HALF > 1) ? $clog2(STEP_HALF) : 1;
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(STEP_HALF - 1);
   localparam logic [DIV_W-1:0]   DIV_MIN_V  = DIV_W'(DIV_MIN);
   localparam logic [DIV_W-1:0]   DIV_DEF_V  = DIV_W'(DIV_DEFAULT);

   typedef enum logic [1:0] {IDLE, RUN, RAMP} state_t;

   state_t             state, state_nxt;
   logic [DIV_W-1:0]   cnt, cnt_nxt;
   logic [DIV_W-1:0]   target, target_nxt;
   logic [DIV_W-1:0]   cur_nxt;
   logic [DIV_W-1:0]   req_div;
   logic [DIV_W-1:0]   stepped;
   logic [DWELL_W-1:0] dwell, dwell_nxt;
   logic               car_nxt;
   logic               clamp_nxt;
   logic               accept;
   logic               wrap;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         dwell       <= '0;
         car_clk     <= 1'b0;
         cmd_clamped <= 1'b0;
         cur_div     <= DIV_DEF_V;
         target      <= DIV_DEF_V;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         dwell       <= dwell_nxt;
         car_clk     <= car_nxt;
         cmd_clamped <= clamp_nxt;
         cur_div     <= cur_nxt;
         target      <= target_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      dwell_nxt  = dwell;
      car_nxt    = car_clk;
      cur_nxt    = cur_div;
      target_nxt = target;

      cmd_ready = (state != RAMP);
      ramping   = (state == RAMP);
      accept    = cmd_valid && cmd_ready;
      req_div   = (cmd_div < DIV_MIN_V) ? DIV_MIN_V : cmd_div;
      clamp_nxt = accept && (cmd_div < DIV_MIN_V);
      wrap      = (state != IDLE) && (cnt == cur_div);
      tick      = wrap;
      stepped   = (cur_div < target) ? cur_div + 1'b1 : cur_div - 1'b1;

      // While stopped there is no carrier to protect, so the divider jumps directly.
      if (accept) begin
         target_nxt = req_div;
         if (state == IDLE) cur_nxt = req_div;
      end

      if (state != IDLE) begin
         if (wrap) begin
            cnt_nxt = '0;
            car_nxt = ~car_clk;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end

      if (!enable) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         car_nxt   = 1'b0;
         dwell_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               cnt_nxt   = '0;
               car_nxt   = 1'b0;
               dwell_nxt = '0;
               state_nxt = (target_nxt == cur_nxt) ? RUN : RAMP;
            end
            RUN: begin
               if (accept && (req_div != cur_div)) state_nxt = RAMP;
            end
            RAMP: begin
               // Divider only moves on a wrap so the running half-period completes intact.
               if (wrap) begin
                  if (dwell == DWELL_LAST) begin
                     cur_nxt   = stepped;
                     dwell_nxt = '0;
                     if (stepped == target) state_nxt = RUN;
                  end else begin
                     dwell_nxt = dwell + 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spwm_rate_sched.sv
// Bench for spwm_rate_sched: directed scenarios plus randomized commands,
// checked every cycle against a behavioural carrier/ramp model.
module tb_spwm_rate_sched;

   localparam int DW   = 13;
   localparam int DDEF = 196;
   localparam int DMIN = 49;
   localparam int SH   = 2;

   logic          clk_in = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          cmd_valid = 1'b0;
   logic [DW-1:0] cmd_div = '0;
   logic          cmd_ready, car_clk, tick, ramping, cmd_clamped;
   logic [DW-1:0] cur_div;

   spwm_rate_sched #(.DIV_W(DW), .DIV_DEFAULT(DDEF), .DIV_MIN(DMIN), .STEP_HALF(SH)) dut (
      .clk_in(clk_in), .reset(reset), .enable(enable), .cmd_valid(cmd_valid),
      .cmd_div(cmd_div), .cmd_ready(cmd_ready), .car_clk(car_clk), .tick(tick),
      .cur_div(cur_div), .ramping(ramping), .cmd_clamped(cmd_clamped)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Reference: mode 0 stopped, 1 steady, 2 ramping; pos = cycles into the half-period.
   int m_mode, m_pos, m_cur, m_tgt, m_half, m_car, m_clp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_cur = DDEF; m_tgt = DDEF; m_half = 0; m_car = 0; m_clp = 0;
   endtask

   task automatic model_edge(input bit en, input bit v, input int d);
      bit acc, wrap;
      int req;
      acc   = v && (m_mode != 2);
      req   = (d < DMIN) ? DMIN : d;
      wrap  = (m_mode != 0) && (m_pos == m_cur);
      m_clp = (acc && d < DMIN) ? 1 : 0;
      if (acc) begin
         m_tgt = req;
         if (m_mode == 0) m_cur = req;
      end
      if (!en) begin
         m_mode = 0; m_pos = 0; m_car = 0; m_half = 0;
      end else if (m_mode == 0) begin
         m_pos = 0; m_car = 0; m_half = 0;
         m_mode = (m_tgt == m_cur) ? 1 : 2;
      end else begin
         m_pos = wrap ? 0 : m_pos + 1;
         if (wrap) m_car = 1 - m_car;
         if (m_mode == 1) begin
            if (acc && req != m_cur) m_mode = 2;
         end else if (wrap) begin
            m_half++;
            if (m_half == SH) begin
               m_half = 0;
               m_cur  = m_cur + ((m_tgt > m_cur) ? 1 : -1);
               if (m_cur == m_tgt) m_mode = 1;
            end
         end
      end
   endtask

   task automatic check_outputs();
      chk("tick",        tick,        (m_mode != 0 && m_pos == m_cur) ? 1 : 0);
      chk("car_clk",     car_clk,     m_car);
      chk("cur_div",     cur_div,     m_cur);
      chk("ramping",     ramping,     (m_mode == 2) ? 1 : 0);
      chk("cmd_ready",   cmd_ready,   (m_mode != 2) ? 1 : 0);
      chk("cmd_clamped", cmd_clamped, m_clp);
   endtask

   task automatic step();
      @(posedge clk_in);
      model_edge(enable, cmd_valid, int'(cmd_div));
      @(negedge clk_in);
      cyc++;
      check_outputs();
   endtask

   task automatic issue(input int d);
      cmd_div   = DW'(d);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   int tq[$];
   int rises[$];
   int prev_car, ntk, n195, n194;

   initial begin
      // Reset values
      reset = 1'b1;
      @(negedge clk_in);
      model_reset();
      check_outputs();
      chk("rst_cur_div", cur_div, DDEF);
      reset = 1'b0;

      // Default rate, no command
      enable = 1'b1;
      prev_car = 0;
      for (int k = 0; k < 800; k++) begin
         step();
         if (tick) tq.push_back(cyc);
         if (car_clk && prev_car == 0) rises.push_back(cyc);
         prev_car = car_clk;
      end
      chk("default_tick_count", (tq.size() >= 3) ? 1 : 0, 1);
      if (tq.size() >= 3) begin
         chk("default_tick_gap1", tq[1] - tq[0], 197);
         chk("default_tick_gap2", tq[2] - tq[1], 197);
      end
      chk("default_rise_count", (rises.size() >= 2) ? 1 : 0, 1);
      if (rises.size() >= 2) chk("default_car_period", rises[1] - rises[0], 394);

      // Command while stopped loads directly, no ramp
      enable = 1'b0;
      step();
      issue(99);
      chk("idle_load_cur", cur_div, 99);
      enable = 1'b1;
      tq.delete();
      for (int k = 0; k < 300; k++) begin
         step();
         if (tick) tq.push_back(cyc);
         if (ramping) chk("idle_load_no_ramp", ramping, 0);
      end
      chk("idle_load_tick_count", (tq.size() >= 2) ? 1 : 0, 1);
      if (tq.size() >= 2) chk("idle_load_tick_gap", tq[1] - tq[0], 100);

      // Ramp 196 -> 194 with STEP_HALF=2
      enable = 1'b0;
      step();
      issue(196);
      enable = 1'b1;
      step();
      issue(194);
      chk("ramp_ready_low", cmd_ready, 0);
      chk("ramp_flag", ramping, 1);
      ntk = tick ? 1 : 0;
      n195 = -1;
      n194 = -1;
      for (int k = 0; k < 4000 && cur_div != 194; k++) begin
         step();
         if (cur_div == 195 && n195 < 0) n195 = ntk;
         if (cur_div == 194 && n194 < 0) n194 = ntk;
         if (tick) ntk++;
      end
      chk("ramp_ticks_to_195", n195, 2);
      chk("ramp_ticks_to_194", n194, 4);
      chk("ramp_done_flag", ramping, 0);
      chk("ramp_done_ready", cmd_ready, 1);

      // Clamp to DIV_MIN
      enable = 1'b0;
      step();
      issue(10);
      chk("clamp_pulse", cmd_clamped, 1);
      chk("clamp_cur", cur_div, DMIN);
      step();
      chk("clamp_pulse_end", cmd_clamped, 0);

      // Enable dropped mid-ramp, then resumed
      issue(196);
      enable = 1'b1;
      step();
      issue(194);
      for (int k = 0; k < 2000 && cur_div != 195; k++) step();
      chk("drop_at_195", cur_div, 195);
      chk("drop_ramping_before", ramping, 1);
      enable = 1'b0;
      step();
      chk("drop_idle_ramping", ramping, 0);
      chk("drop_idle_car", car_clk, 0);
      chk("drop_idle_cur", cur_div, 195);
      enable = 1'b1;
      step();
      chk("resume_ramping", ramping, 1);
      for (int k = 0; k < 2000 && cur_div != 194; k++) step();
      chk("resume_reach_194", cur_div, 194);
      step();
      chk("resume_run", ramping, 0);

      // Randomized commands and enable activity
      for (int it = 0; it < 40; it++) begin
         enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 2) != 0) begin
            if (!enable && $urandom_range(0, 1) == 1) issue(int'($urandom_range(0, 70)));
            else issue(m_cur + int'($urandom_range(0, 4)) - 2);
         end else begin
            step();
         end
         repeat ($urandom_range(1, 250)) step();
      end

      // Asynchronous reset mid-ramp
      enable = 1'b1;
      for (int k = 0; k < 5000 && !(cmd_ready && !ramping && m_mode == 1); k++) step();
      issue(m_cur + 1);
      repeat (150) step();
      chk("async_pre_ramping", ramping, 1);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs();
      chk("async_rst_cur", cur_div, DDEF);
      chk("async_rst_ready", cmd_ready, 1);
      @(negedge clk_in);
      enable = 1'b0;
      reset  = 1'b0;
      repeat (5) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
